int8_fc_stream_driver: RTL
==========================

# int8_fc_stream_driver

Initiator-side front end for the pipelined INT8 FC engine (int8_fc_pipelined). It assembles an input vector from a byte stream and launches the engine with a one-cycle start pulse. It waits for done, captures the result vector, and serializes it back out as a framed byte stream. It sits between a byte-oriented link (UART RX/TX bridge or DMA byte port) and the FC engine.

## Interface
- IN, 8, input vector length (bytes per input frame); must match engine IN
- OUT, 4, output vector length (bytes per output frame); must match engine OUT
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with FC_DRV_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  input byte, signed INT8
- fc_start  out  1  one-cycle launch pulse to engine
- fc_x  out  8 x IN  input vector to engine, signed
- fc_done  in  1  engine completion pulse; fc_y valid in the same cycle
- fc_y  in  8 x OUT  engine result vector, signed
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  8  output byte, signed INT8
- m_last  out  1  high with the final byte (index OUT-1) of a frame
- busy  out  1  high in KICK, WAIT, DRAIN
- frame_count  out  16  completed output frames, wraps 0xFFFF->0
- err_timeout  out  1  sticky watchdog error

## Operation
- States: LOAD, KICK, WAIT, DRAIN. Reset state is LOAD.
- LOAD
  - s_ready=1.
  - Each accepted byte is written to xbuf[in_idx], then in_idx increments.
  - The byte accepted at in_idx==IN-1 moves the state to KICK and clears in_idx.
- KICK
  - fc_start=1 for exactly one cycle, then WAIT.
- WAIT
  - fc_done=1 captures fc_y into ybuf, clears out_idx, and moves to DRAIN.
- DRAIN
  - m_valid=1, m_data=ybuf[out_idx], m_last=(out_idx==OUT-1).
  - Each handshake advances out_idx.
  - The handshake with m_last moves to LOAD and increments frame_count.
- fc_x is driven directly from xbuf. xbuf is written only in LOAD, so it is stable from KICK through the done cycle.
- fc_done outside WAIT is ignored: no capture and no state change.
- Byte values pass through unmodified. No arithmetic is performed on data; counters use widths of $clog2(IN) and $clog2(OUT) (minimum 1 bit).
- Reset mid-frame drops the partial input frame and any undrained output. The state returns to LOAD.

## Timing
- Reset values: s_ready=0 while rst is high, then 1 in the first cycle after rst falls (LOAD). All other outputs and counters are 0, and xbuf/ybuf are 0.
- All outputs are registered or decoded from registered state. There is no combinational path from s_valid/m_ready/fc_done to any output.
- Input side: the last-byte handshake in cycle t gives fc_start=1 in cycle t+1. fc_x is complete in cycle t+1.
- Done side: fc_done in cycle d gives m_valid=1 with ybuf[0] in cycle d+1.
- Output side: m_data/m_last hold stable while m_valid && !m_ready. One byte per cycle at full rate.
- Turnaround: the m_last handshake in cycle e gives s_ready=1 in cycle e+1. There is no input/output overlap (single buffered).
- Minimum frame period: IN + 1 + engine latency + OUT + 1 cycles.

## Configuration
- FC_DRV_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If fc_done is not seen within TIMEOUT_CYCLES cycles after entering WAIT, err_timeout is set, the frame is dropped (no output bytes, frame_count unchanged), and the state returns to LOAD.
  - err_timeout stays set until rst.
  - fc_done in the same cycle the limit is hit counts as success.
- FC_DRV_TIMEOUT_EN undefined: WAIT has no limit, there is no counter logic, and err_timeout is tied to 0.

## Structure
- Shared package fc_pkg: int8_t typedef, fc_drv_state_e enum (LOAD, KICK, WAIT, DRAIN), default IN/OUT constants shared with the engine.
- There is no sub-module. This is a single FSM with xbuf/ybuf register arrays.

## Test plan
Bench instantiates int8_fc_pipelined with defaults (IN=8, OUT=4, SHIFT=7).
- Single frame: send bytes 1,1,1,1,1,1,1,1 with s_valid held and m_ready=1 -> exactly one fc_start pulse, then output 0x0A, 0xEC, 0x05, 0x00 with m_last on 0x00, and frame_count=1.
- Input gaps: same frame with s_valid toggling every other cycle -> identical output bytes, and fc_start only after the 8th byte.
- Output backpressure: m_ready low for 5 cycles at byte index 2 -> m_data stays 0x05 with m_valid high, no byte lost or duplicated, and s_ready stays 0 until after m_last.
- Back-to-back: 3 consecutive frames -> 12 output bytes, frame_count=3, and fc_start exactly 3 times.
- Reset mid-operation: assert rst after 5 input bytes, then send a full frame -> only one output frame, correct values, and frame_count=1.
- With FC_DRV_TIMEOUT_EN and a stub engine that never asserts done: after TIMEOUT_CYCLES in WAIT -> err_timeout=1 (sticky), state LOAD, s_ready=1, no m_valid.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default dimensions for the INT8 FC engine and its stream driver.
package fc_pkg;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fc_drv_state_e;

  localparam int unsigned FC_IN  = 8;
  localparam int unsigned FC_OUT = 4;

  // Index width for an n-entry buffer, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int8_fc_stream_driver.sv
// Byte-stream front end for the INT8 FC engine: gathers an input frame, launches the engine, drains the result.
// Optional WAIT watchdog is enabled by defining FC_DRV_TIMEOUT_EN.
module int8_fc_stream_driver
  import fc_pkg::*;
#(
  parameter int unsigned IN  = FC_IN,
  parameter int unsigned OUT = FC_OUT
`ifdef FC_DRV_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  output logic                fc_start,
  output logic [IN-1:0][7:0]  fc_x,
  input  logic                fc_done,
  input  logic [OUT-1:0][7:0] fc_y,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [7:0]          m_data,
  output logic                m_last,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic                err_timeout
);

  localparam int unsigned IN_IDX_W  = idx_width(IN);
  localparam int unsigned OUT_IDX_W = idx_width(OUT);
  localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(IN - 1);
  localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(OUT - 1);

  fc_drv_state_e          state_q, state_d;
  logic [IN_IDX_W-1:0]    in_idx_q, in_idx_d;
  logic [OUT_IDX_W-1:0]   out_idx_q, out_idx_d;
  int8_t [IN-1:0]         xbuf_q, xbuf_d;
  int8_t [OUT-1:0]        ybuf_q, ybuf_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   s_ready_q, s_ready_d;

`ifdef FC_DRV_TIMEOUT_EN
  localparam int unsigned WAIT_CNT_W = idx_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   err_timeout_q, err_timeout_d;
`endif

  // Next-state and datapath update; buffers only change on their own handshakes.
  always_comb begin
    state_d       = state_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    xbuf_d        = xbuf_q;
    ybuf_d        = ybuf_q;
    frame_count_d = frame_count_q;
`ifdef FC_DRV_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
`endif

    unique case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          xbuf_d[in_idx_q] = s_data;
          if (in_idx_q == IN_LAST) begin
            in_idx_d = '0;
            state_d  = KICK;
          end else begin
            in_idx_d = in_idx_q + IN_IDX_W'(1);
          end
        end
      end
      KICK: begin
        state_d = WAIT;
`ifdef FC_DRV_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (fc_done) begin
          ybuf_d    = fc_y;
          out_idx_d = '0;
          state_d   = DRAIN;
        end
`ifdef FC_DRV_TIMEOUT_EN
        // A done arriving on the limit cycle still wins over the watchdog.
        else if (wait_cnt_q == WAIT_LIMIT) begin
          err_timeout_d = 1'b1;
          state_d       = LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (m_ready) begin
          if (out_idx_q == OUT_LAST) begin
            out_idx_d     = '0;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = LOAD;
          end else begin
            out_idx_d = out_idx_q + OUT_IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      xbuf_q        <= '0;
      ybuf_q        <= '0;
      frame_count_q <= '0;
      s_ready_q     <= 1'b0;
`ifdef FC_DRV_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      in_idx_q      <= in_idx_d;
      out_idx_q     <= out_idx_d;
      xbuf_q        <= xbuf_d;
      ybuf_q        <= ybuf_d;
      frame_count_q <= frame_count_d;
      s_ready_q     <= s_ready_d;
`ifdef FC_DRV_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  // Outputs are flops or pure decodes of flops.
  assign s_ready     = s_ready_q;
  assign fc_start    = (state_q == KICK);
  assign fc_x        = xbuf_q;
  assign m_valid     = (state_q == DRAIN);
  assign m_data      = ybuf_q[out_idx_q];
  assign m_last      = (state_q == DRAIN) && (out_idx_q == OUT_LAST);
  assign busy        = (state_q != LOAD);
  assign frame_count = frame_count_q;
`ifdef FC_DRV_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
